// File: rtl/tank_multishot.sv
// Tank controller: movement with brick/boundary collision, N bullet slots, fire edge-detect
// with cooldown, lives and timed respawn with invulnerability. One update per frame_clk edge.
// Latency: all outputs are registered and change one frame after the inputs that cause them.
// Backpressure: none. A fire edge that cannot be served (cooldown or no free slot) is dropped.
// Ports:
//   frame_clk, Reset (async, active high)
//   move_up/down/left/right, fire, hit_in, bullet_kill[N]   frame-rate requests
//   brick_map[row][39-col]                                    shared 30x40 map of 16px cells
//   TankX/TankY/TankDir/tank_state/lives/blocked              tank status
//   bullet_active/bullet_x/bullet_y/bullet_dir                per-slot bullet status, slot i packed at i
module tank_multishot #(
   parameter int         N_BULLETS     = 2,
   parameter int         TANK_STEP     = 2,
   parameter int         BULLET_STEP   = 8,
   parameter int         FIRE_COOLDOWN = 8,
   parameter int         RESPAWN_DELAY = 30,
   parameter int         INVULN_FRAMES = 60,
   parameter int         START_LIVES   = 3,
   parameter int         SPAWN_X       = 230,
   parameter int         SPAWN_Y       = 240,
   parameter logic [3:0] SPAWN_DIR     = 4'b0001,
   parameter int         X_MIN         = 80,
   parameter int         X_MAX         = 528,
   parameter int         Y_MIN         = 0,
   parameter int         Y_MAX         = 448
) (
   input  logic                     frame_clk,
   input  logic                     Reset,
   input  logic                     move_up,
   input  logic                     move_down,
   input  logic                     move_left,
   input  logic                     move_right,
   input  logic                     fire,
   input  logic                     hit_in,
   input  logic [N_BULLETS-1:0]     bullet_kill,
   input  logic [29:0][39:0]        brick_map,
   output logic [9:0]               TankX,
   output logic [9:0]               TankY,
   output logic [3:0]               TankDir,
   output logic [1:0]               tank_state,
   output logic [2:0]               lives,
   output logic                     blocked,
   output logic [N_BULLETS-1:0]     bullet_active,
   output logic [10*N_BULLETS-1:0]  bullet_x,
   output logic [10*N_BULLETS-1:0]  bullet_y,
   output logic [4*N_BULLETS-1:0]   bullet_dir
);

   typedef enum logic [1:0] {
      ST_ALIVE    = 2'b00,
      ST_DEAD     = 2'b01,
      ST_INVULN   = 2'b10,
      ST_GAMEOVER = 2'b11
   } state_t;

   localparam int CD_W = (FIRE_COOLDOWN < 1) ? 1 : $clog2(FIRE_COOLDOWN + 1);

   // Positions are evaluated as 12-bit signed so that steps past the field edge compare correctly.
   localparam logic signed [11:0] TSTEP  = 12'(TANK_STEP);
   localparam logic signed [11:0] BSTEP  = 12'(BULLET_STEP);
   localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
   localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
   localparam logic signed [11:0] YMIN_S = 12'(Y_MIN);
   localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);

   // Solid test for one pixel; anything outside the 640x480 map is open.
   function automatic logic solid_at(input logic [29:0][39:0] map,
                                     input logic signed [11:0] px,
                                     input logic signed [11:0] py);
      logic [5:0] col;
      logic [4:0] row;
      col = px[9:4];
      row = py[8:4];
      if (px < 12'sd0 || py < 12'sd0 || px > 12'sd639 || py > 12'sd479)
         return 1'b0;
      return map[row][6'd39 - col];
   endfunction

   // Tank collision sample offsets along one axis: left/top edge, middle, right/bottom edge.
   function automatic logic signed [11:0] pt_ofs(input int k);
      if (k == 0) return 12'sd0;
      if (k == 1) return 12'sd15;
      return 12'sd31;
   endfunction

   state_t                 state_q, state_d;
   logic [6:0]             cnt_q, cnt_d;
   logic [2:0]             lives_q, lives_d;
   logic [9:0]             tank_x_q, tank_x_d, tank_y_q, tank_y_d;
   logic [3:0]             dir_q, dir_d;
   logic                   blocked_q, blocked_d;
   logic                   fire_prev;
   logic [CD_W-1:0]        cooldown;

   logic [N_BULLETS-1:0]   b_act;
   logic [9:0]             b_x   [N_BULLETS];
   logic [9:0]             b_y   [N_BULLETS];
   logic [3:0]             b_dir [N_BULLETS];
   logic [9:0]             b_nx  [N_BULLETS];
   logic [9:0]             b_ny  [N_BULLETS];
   logic [N_BULLETS-1:0]   b_ret;

   logic                   act, respawn, shot, have_free;
   logic [1:0]             free_idx;
   logic [9:0]             spawn_bx, spawn_by;
   logic                   mv_req, mv_ok, mv_hit;
   logic [3:0]             mv_dir;
   logic signed [11:0]     cand_x, cand_y;

   // Movement candidate: only the highest-priority request is considered.
   always_comb begin
      mv_req = 1'b0;
      mv_dir = dir_q;
      cand_x = $signed({2'b00, tank_x_q});
      cand_y = $signed({2'b00, tank_y_q});
      if (move_up) begin
         mv_req = 1'b1; mv_dir = 4'b0001; cand_y = cand_y - TSTEP;
      end else if (move_down) begin
         mv_req = 1'b1; mv_dir = 4'b0010; cand_y = cand_y + TSTEP;
      end else if (move_left) begin
         mv_req = 1'b1; mv_dir = 4'b0100; cand_x = cand_x - TSTEP;
      end else if (move_right) begin
         mv_req = 1'b1; mv_dir = 4'b1000; cand_x = cand_x + TSTEP;
      end
      mv_hit = 1'b0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            mv_hit = mv_hit | solid_at(brick_map, cand_x + pt_ofs(i), cand_y + pt_ofs(j));
      mv_ok = (cand_x >= XMIN_S) && (cand_x <= XMAX_S) &&
              (cand_y >= YMIN_S) && (cand_y <= YMAX_S) && !mv_hit;
   end

   // Bullet flight: next position and retire decision per slot.
   always_comb begin : bullet_next
      logic signed [11:0] bx, by;
      bx = '0;
      by = '0;
      for (int i = 0; i < N_BULLETS; i++) begin
         bx = $signed({2'b00, b_x[i]});
         by = $signed({2'b00, b_y[i]});
         if (b_dir[i][0])      by = by - BSTEP;
         else if (b_dir[i][1]) by = by + BSTEP;
         else if (b_dir[i][2]) bx = bx - BSTEP;
         else if (b_dir[i][3]) bx = bx + BSTEP;
         b_nx[i]  = bx[9:0];
         b_ny[i]  = by[9:0];
         b_ret[i] = bullet_kill[i] ||
                    (bx + 12'sd8 < XMIN_S) || (bx > XMAX_S + 12'sd32) ||
                    (by + 12'sd8 < YMIN_S) || (by > YMAX_S + 12'sd32) ||
                    solid_at(brick_map, bx, by) ||
                    solid_at(brick_map, bx + 12'sd7, by) ||
                    solid_at(brick_map, bx, by + 12'sd7) ||
                    solid_at(brick_map, bx + 12'sd7, by + 12'sd7);
      end
   end

   // Lowest free slot wins: scan downward so the last hit is the lowest index.
   always_comb begin
      have_free = 1'b0;
      free_idx  = '0;
      for (int i = N_BULLETS - 1; i >= 0; i--)
         if (!b_act[i]) begin
            have_free = 1'b1;
            free_idx  = 2'(i);
         end
   end

   // Muzzle position relative to the current (pre-move) tank position.
   always_comb begin
      spawn_bx = tank_x_q + 10'd12;
      spawn_by = tank_y_q - 10'd8;
      case (dir_q)
         4'b0010: begin spawn_bx = tank_x_q + 10'd12; spawn_by = tank_y_q + 10'd32; end
         4'b0100: begin spawn_bx = tank_x_q - 10'd8;  spawn_by = tank_y_q + 10'd12; end
         4'b1000: begin spawn_bx = tank_x_q + 10'd32; spawn_by = tank_y_q + 10'd12; end
         default: ;
      endcase
   end

   // Life-cycle FSM plus tank position/facing next state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lives_d   = lives_q;
      act       = 1'b0;
      respawn   = 1'b0;
      tank_x_d  = tank_x_q;
      tank_y_d  = tank_y_q;
      dir_d     = dir_q;
      blocked_d = 1'b0;
      case (state_q)
         ST_ALIVE: begin
            // A hit takes the whole frame: no move and no shot alongside it.
            if (hit_in) begin
               if (lives_q > 3'd1) begin
                  state_d = ST_DEAD;
                  lives_d = lives_q - 3'd1;
                  cnt_d   = 7'(RESPAWN_DELAY);
               end else begin
                  state_d = ST_GAMEOVER;
                  lives_d = '0;
               end
            end else begin
               act = 1'b1;
            end
         end
         ST_DEAD: begin
            if (cnt_q == '0) begin
               state_d = ST_INVULN;
               cnt_d   = 7'(INVULN_FRAMES);
               respawn = 1'b1;
            end else begin
               cnt_d = cnt_q - 7'd1;
            end
         end
         ST_INVULN: begin
            act = 1'b1;
            if (cnt_q == '0) state_d = ST_ALIVE;
            else             cnt_d   = cnt_q - 7'd1;
         end
         default: ;
      endcase

      if (respawn) begin
         tank_x_d = 10'(SPAWN_X);
         tank_y_d = 10'(SPAWN_Y);
         dir_d    = SPAWN_DIR;
      end else if (act && mv_req) begin
         dir_d = mv_dir;
         if (mv_ok) begin
            tank_x_d = cand_x[9:0];
            tank_y_d = cand_y[9:0];
         end else begin
            blocked_d = 1'b1;
         end
      end

      shot = act && fire && !fire_prev && (cooldown == '0) && have_free;
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_INVULN;
         cnt_q     <= 7'(INVULN_FRAMES);
         lives_q   <= 3'(START_LIVES);
         tank_x_q  <= 10'(SPAWN_X);
         tank_y_q  <= 10'(SPAWN_Y);
         dir_q     <= SPAWN_DIR;
         blocked_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lives_q   <= lives_d;
         tank_x_q  <= tank_x_d;
         tank_y_q  <= tank_y_d;
         dir_q     <= dir_d;
         blocked_q <= blocked_d;
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         fire_prev <= 1'b0;
         cooldown  <= '0;
         b_act     <= '0;
         for (int i = 0; i < N_BULLETS; i++) begin
            b_x[i]   <= '0;
            b_y[i]   <= '0;
            b_dir[i] <= 4'b0001;
         end
      end else begin
         fire_prev <= fire;
         if (shot)                cooldown <= CD_W'(FIRE_COOLDOWN);
         else if (cooldown != '0) cooldown <= cooldown - CD_W'(1);
         for (int i = 0; i < N_BULLETS; i++) begin
            if (b_act[i]) begin
               // Retired slots keep their last position; they only free up next frame.
               if (b_ret[i]) begin
                  b_act[i] <= 1'b0;
               end else begin
                  b_x[i] <= b_nx[i];
                  b_y[i] <= b_ny[i];
               end
            end else if (shot && free_idx == 2'(i)) begin
               b_act[i] <= 1'b1;
               b_x[i]   <= spawn_bx;
               b_y[i]   <= spawn_by;
               b_dir[i] <= dir_q;
            end
         end
      end
   end

   always_comb begin
      bullet_x   = '0;
      bullet_y   = '0;
      bullet_dir = '0;
      for (int i = 0; i < N_BULLETS; i++) begin
         bullet_x[10*i +: 10] = b_x[i];
         bullet_y[10*i +: 10] = b_y[i];
         bullet_dir[4*i +: 4] = b_dir[i];
      end
   end

   assign TankX         = tank_x_q;
   assign TankY         = tank_y_q;
   assign TankDir       = dir_q;
   assign tank_state    = state_q;
   assign lives         = lives_q;
   assign blocked       = blocked_q;
   assign bullet_active = b_act;

endmodule
